// File: rtl/sseg_scan_display_pkg.sv
// rtl/sseg_scan_display_pkg.sv - shared constants for the seven-segment scanner
package sseg_scan_display_pkg;

  typedef enum logic {
    ST_DRIVE = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  // Lit-segment patterns, active-high, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // All anodes released (active-low anodes)
  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/sseg_scan_display_bcd_to_sseg.sv
// rtl/sseg_scan_display_bcd_to_sseg.sv - BCD digit to active-high segment pattern
module bcd_to_sseg
  import sseg_scan_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Decimal codes get their glyph; anything above 9 shows a dash.
  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sseg_scan_display.sv
// rtl/sseg_scan_display.sv - 4-digit multiplexed seven-segment driver with blanking gap
module sseg_scan_display
  import sseg_scan_display_pkg::*;
#(
  parameter int DVSR         = 100000,
  parameter int N            = 17,
  parameter int BLANK_CYCLES = 1000,
  parameter int BW           = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        lz_blank,
  input  logic [3:0]  dp_mask,
  input  logic [15:0] digits,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [N-1:0]  PRESC_LAST = N'(DVSR - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [N-1:0]  presc_q, presc_d;
  logic [BW-1:0] blank_q, blank_d;

  logic [15:0]   snap_digits_q;
  logic [3:0]    snap_dp_q;
  logic          snap_lz_q;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          capture;
  logic [15:0]   cur_digits;
  logic [3:0]    cur_dp;
  logic          cur_lz;
  logic [3:0]    sel_bcd;
  logic [6:0]    pattern;
  logic          digit_blank;

  // Frame start: the snapshot loads this cycle, and digit 0 already shows the new value
  assign capture    = (state_q == ST_DRIVE) && (idx_q == 2'd0) && (presc_q == '0);
  assign cur_digits = capture ? digits   : snap_digits_q;
  assign cur_dp     = capture ? dp_mask  : snap_dp_q;
  assign cur_lz     = capture ? lz_blank : snap_lz_q;
  assign sel_bcd    = cur_digits[{idx_q, 2'b00} +: 4];

  // Digit 2 only blanks when the whole upper byte is zero, so "0 5" never appears as " 5" with a gap
  assign digit_blank = cur_lz &&
                       (((idx_q == 2'd3) && (cur_digits[15:12] == 4'd0)) ||
                        ((idx_q == 2'd2) && (cur_digits[15:8]  == 8'd0)));

  bcd_to_sseg u_dec (
    .bcd_i (sel_bcd),
    .seg_o (pattern)
  );

  // State, counters, snapshot and registered pin drivers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_DRIVE;
      idx_q         <= 2'd0;
      presc_q       <= '0;
      blank_q       <= '0;
      snap_digits_q <= 16'h0000;
      snap_dp_q     <= 4'h0;
      snap_lz_q     <= 1'b0;
      an_q          <= AN_OFF;
      seg_q         <= ~SEG_OFF;
      dp_q          <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      if (capture) begin
        snap_digits_q <= digits;
        snap_dp_q     <= dp_mask;
        snap_lz_q     <= lz_blank;
      end
    end
  end

  // Scan sequencing: drive a digit for DVSR cycles, then hold all anodes off for the gap
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    blank_d = blank_q;
    case (state_q)
      ST_DRIVE: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (BLANK_CYCLES == 0) begin
            idx_d = idx_q + 2'd1;
          end else begin
            state_d = ST_BLANK;
          end
        end else begin
          presc_d = presc_q + N'(1);
        end
      end
      ST_BLANK: begin
        presc_d = '0;
        if (blank_q == BLANK_LAST) begin
          blank_d = '0;
          idx_d   = idx_q + 2'd1;
          state_d = ST_DRIVE;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_DRIVE;
      end
    endcase
  end

  // Pin values for next cycle; dark unless driving an enabled, non-suppressed digit
  always_comb begin
    an_d  = AN_OFF;
    seg_d = ~SEG_OFF;
    dp_d  = 1'b1;
    if ((state_q == ST_DRIVE) && enable && !digit_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = ~pattern;
      dp_d  = ~cur_dp[idx_q];
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
